// File: rtl/vga_entity_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_entity_update_scheduler
// Purpose  : Stages CPU entity writes in a FIFO and drains the committed ones
//            into the entity bank during vertical blank, so sprites never tear.
// Revision : 1.0 - initial release
// ============================================================================
module vga_entity_update_scheduler #(
    parameter int DEPTH = 64,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic [1:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    input  logic        VBLANK,
    output logic        ENT_WRITE,
    output logic [7:0]  ENT_ADDR,
    output logic [31:0] ENT_WRITEDATA,
    output logic        IRQ
);
    localparam int         c_PTR_W = $clog2(DEPTH);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [7:0]         r_stage_addr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   r_commit_cnt;
    logic               r_done;
    logic               r_overflow;
    logic               r_split;
    logic               r_vblank_q;
    logic [39:0]        r_mem [DEPTH];

    logic               w_addr_wr;
    logic               w_data_wr;
    logic               w_ctrl_wr;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_commit;
    logic               w_vblank_rise;
    logic               w_busy;
    logic [LVL_W-1:0]   w_level_eff;
    logic [39:0]        w_head;
    logic               w_unused_read;

    assign w_unused_read = AVL_READ;

    assign w_addr_wr     = AVL_WRITE && (AVL_ADDR == 2'd0);
    assign w_data_wr     = AVL_WRITE && (AVL_ADDR == 2'd1);
    assign w_ctrl_wr     = AVL_WRITE && (AVL_ADDR == 2'd2);
    assign w_full        = (r_level == LVL_W'(DEPTH));
    assign w_push        = w_data_wr && !w_full;
    assign w_flush       = w_ctrl_wr && AVL_WRITEDATA[1] && (r_state == c_IDLE);
    assign w_commit      = w_ctrl_wr && AVL_WRITEDATA[0] && (r_state == c_IDLE);
    // A flush in the same write as a commit makes the commit see an empty FIFO.
    assign w_level_eff   = w_flush ? '0 : r_level;
    assign w_vblank_rise = VBLANK && !r_vblank_q;
    assign w_busy        = (r_state != c_IDLE);
    assign w_head        = r_mem[r_rd_ptr];

    // The first pop is taken on the rising edge itself so the bank sees it one cycle later.
    assign w_pop = ((r_state == c_ARMED) && w_vblank_rise) ||
                   ((r_state == c_DRAIN) && (r_commit_cnt != '0) && VBLANK);

    assign IRQ = r_done;

    always_comb begin
        AVL_READDATA = '0;
        case (AVL_ADDR)
            2'd0:    AVL_READDATA = {24'd0, r_stage_addr};
            2'd3:    AVL_READDATA = {12'd0, r_split, r_done, r_overflow, w_busy, 16'(r_level)};
            default: AVL_READDATA = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_stage_addr, AVL_WRITEDATA};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= c_IDLE;
            r_stage_addr  <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_commit_cnt  <= '0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_split       <= 1'b0;
            r_vblank_q    <= 1'b0;
            ENT_WRITE     <= 1'b0;
            ENT_ADDR      <= '0;
            ENT_WRITEDATA <= '0;
        end else begin
            r_vblank_q <= VBLANK;

            if (w_addr_wr) begin
                r_stage_addr <= AVL_WRITEDATA[7:0];
            end
            if (w_data_wr) begin
                r_stage_addr <= r_stage_addr + 8'd1;
            end

            if (w_ctrl_wr && AVL_WRITEDATA[2]) r_overflow <= 1'b0;
            if (w_ctrl_wr && AVL_WRITEDATA[3]) r_done     <= 1'b0;
            if (w_ctrl_wr && AVL_WRITEDATA[4]) r_split    <= 1'b0;
            if (w_data_wr && w_full)           r_overflow <= 1'b1;

            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: r_level <= r_level;
                endcase
            end

            ENT_WRITE <= w_pop;
            if (w_pop) begin
                ENT_ADDR      <= w_head[39:32];
                ENT_WRITEDATA <= w_head[31:0];
            end

            case (r_state)
                c_IDLE: begin
                    if (w_commit) begin
                        if (w_level_eff == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_commit_cnt <= w_level_eff;
                            r_state      <= c_ARMED;
                        end
                    end
                end
                c_ARMED: begin
                    if (w_vblank_rise) begin
                        r_commit_cnt <= r_commit_cnt - LVL_W'(1);
                        r_state      <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // Count reaching zero means the last write is on the bus now.
                    if (r_commit_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else if (VBLANK) begin
                        r_commit_cnt <= r_commit_cnt - LVL_W'(1);
                    end else begin
                        r_split <= 1'b1;
                        r_state <= c_ARMED;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_entity_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_entity_update_scheduler
// Purpose  : Directed self-checking bench with an entity-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_entity_update_scheduler;
    localparam int DEPTH = 64;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        AVL_READ = 1'b0;
    logic        AVL_WRITE = 1'b0;
    logic [1:0]  AVL_ADDR = 2'd0;
    logic [31:0] AVL_WRITEDATA = 32'd0;
    logic [31:0] AVL_READDATA;
    logic        VBLANK = 1'b0;
    logic        ENT_WRITE;
    logic [7:0]  ENT_ADDR;
    logic [31:0] ENT_WRITEDATA;
    logic        IRQ;

    int          errors = 0;
    int          checks = 0;
    int          ent_cnt = 0;
    int          base;
    logic [7:0]  m_stage = 8'd0;
    logic [39:0] sb [$];
    logic [31:0] rd;

    vga_entity_update_scheduler #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .VBLANK        (VBLANK),
        .ENT_WRITE     (ENT_WRITE),
        .ENT_ADDR      (ENT_ADDR),
        .ENT_WRITEDATA (ENT_WRITEDATA),
        .IRQ           (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        AVL_WRITE = 1'b1;
        AVL_ADDR = a;
        AVL_WRITEDATA = d;
        if (a == 2'd0) m_stage = d[7:0];
        tick();
        AVL_WRITE = 1'b0;
        AVL_WRITEDATA = 32'd0;
    endtask

    task automatic stage(input logic [31:0] d, input bit track);
        if (track) sb.push_back({m_stage, d});
        m_stage = m_stage + 8'd1;
        AVL_WRITE = 1'b1;
        AVL_ADDR = 2'd1;
        AVL_WRITEDATA = d;
        tick();
        AVL_WRITE = 1'b0;
        AVL_WRITEDATA = 32'd0;
    endtask

    task automatic rd_csr(input logic [1:0] a, output logic [31:0] d);
        AVL_ADDR = a;
        #1;
        d = AVL_READDATA;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        logic [31:0] s;
        rd_csr(2'd3, s);
        check(tag, s, exp);
    endtask

    // Entity-bank monitor: every observed write must match the scoreboard head.
    always @(negedge CLK) begin
        if (!RESET && ENT_WRITE) begin
            ent_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL ent_unexpected observed=%h_%h expected=none", ENT_ADDR, ENT_WRITEDATA);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                check("ent_addr", {24'd0, ENT_ADDR}, {24'd0, e[39:32]});
                check("ent_data", ENT_WRITEDATA, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        RESET = 1'b0;
        tick();
        check("rst_ent_write", {31'd0, ENT_WRITE}, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        chk_status("rst_status", 32'd0);
        rd_csr(2'd0, rd);
        check("rst_stage_addr", rd, 32'd0);

        // Basic commit and drain
        wr(2'd0, 32'h10);
        rd_csr(2'd0, rd);
        check("stage_addr_rb", rd, 32'h10);
        stage(32'hA, 1'b1);
        stage(32'hB, 1'b1);
        stage(32'hC, 1'b1);
        chk_status("basic_level3", 32'h3);
        wr(2'd2, 32'h1);
        chk_status("basic_armed", 32'h10003);
        tick();
        tick();
        check("armed_no_write", {31'd0, ENT_WRITE}, 32'd0);
        base = ent_cnt;
        VBLANK = 1'b1;
        tick();
        check("basic_w1", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        check("basic_w2", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        check("basic_w3", {31'd0, ENT_WRITE}, 32'd1);
        chk_status("basic_busy_last", 32'h10000);
        tick();
        check("basic_w_end", {31'd0, ENT_WRITE}, 32'd0);
        check("basic_irq", {31'd0, IRQ}, 32'd1);
        chk_status("basic_done", 32'h40000);
        check("basic_count", ent_cnt - base, 3);
        VBLANK = 1'b0;
        wr(2'd2, 32'h8);
        chk_status("done_clear", 32'd0);
        check("irq_clear", {31'd0, IRQ}, 32'd0);

        // Zero-entry commit
        wr(2'd2, 32'h1);
        chk_status("zero_commit", 32'h40000);
        check("zero_irq", {31'd0, IRQ}, 32'd1);
        wr(2'd2, 32'h8);

        // Overflow, then flush
        wr(2'd0, 32'h0);
        for (int i = 0; i < 65; i++) stage(32'h1000 + i, 1'b0);
        chk_status("ovf_status", 32'h20040);
        rd_csr(2'd0, rd);
        check("ovf_stage_addr", rd, 32'h41);
        wr(2'd2, 32'h4);
        chk_status("ovf_clear", 32'h40);
        wr(2'd2, 32'h2);
        chk_status("flush", 32'h0);
        stage(32'h55, 1'b0);
        wr(2'd2, 32'h3);
        chk_status("flush_commit", 32'h40000);
        wr(2'd2, 32'h8);

        // Pause and resume
        wr(2'd0, 32'h20);
        for (int i = 0; i < 5; i++) stage(32'h100 + i, 1'b1);
        wr(2'd2, 32'h1);
        tick();
        base = ent_cnt;
        VBLANK = 1'b1;
        tick();
        check("pause_w1", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        check("pause_w2", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        VBLANK = 1'b0;
        check("pause_w3", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        check("pause_gap", {31'd0, ENT_WRITE}, 32'd0);
        chk_status("pause_split", 32'h90002);
        check("pause_count", ent_cnt - base, 3);
        tick();
        tick();
        check("pause_hold", {31'd0, ENT_WRITE}, 32'd0);
        VBLANK = 1'b1;
        tick();
        check("resume_w1", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        check("resume_w2", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        check("resume_end", {31'd0, ENT_WRITE}, 32'd0);
        chk_status("resume_done", 32'hC0000);
        check("resume_count", ent_cnt - base, 5);
        VBLANK = 1'b0;
        wr(2'd2, 32'h18);
        chk_status("split_clear", 32'd0);

        // Post-commit pushes and ignored commit
        wr(2'd0, 32'h30);
        stage(32'h200, 1'b1);
        stage(32'h201, 1'b1);
        wr(2'd2, 32'h1);
        stage(32'h202, 1'b0);
        stage(32'h203, 1'b0);
        stage(32'h204, 1'b0);
        wr(2'd2, 32'h1);
        chk_status("post_armed", 32'h10005);
        base = ent_cnt;
        VBLANK = 1'b1;
        tick();
        tick();
        tick();
        check("post_end", {31'd0, ENT_WRITE}, 32'd0);
        chk_status("post_done", 32'h40003);
        check("post_count", ent_cnt - base, 2);
        VBLANK = 1'b0;
        wr(2'd2, 32'hA);
        chk_status("post_flush", 32'd0);

        // Address wrap and push during drain
        wr(2'd0, 32'hFF);
        stage(32'h300, 1'b1);
        stage(32'h301, 1'b1);
        wr(2'd2, 32'h1);
        tick();
        VBLANK = 1'b1;
        tick();
        check("wrap_addr0", {24'd0, ENT_ADDR}, 32'hFF);
        chk_status("pp_before", 32'h10001);
        stage(32'h302, 1'b1);
        check("wrap_addr1", {24'd0, ENT_ADDR}, 32'h00);
        check("wrap_w2", {31'd0, ENT_WRITE}, 32'd1);
        chk_status("pp_after", 32'h10001);
        tick();
        chk_status("wrap_done", 32'h40001);
        VBLANK = 1'b0;
        wr(2'd2, 32'h8);

        // Reset in the middle of a drain
        stage(32'h303, 1'b0);
        stage(32'h304, 1'b0);
        stage(32'h305, 1'b0);
        chk_status("rm_level", 32'h4);
        wr(2'd2, 32'h1);
        tick();
        VBLANK = 1'b1;
        tick();
        check("rm_w1", {31'd0, ENT_WRITE}, 32'd1);
        tick();
        #1;
        RESET = 1'b1;
        #1;
        check("rm_ent_write", {31'd0, ENT_WRITE}, 32'd0);
        check("rm_ent_addr", {24'd0, ENT_ADDR}, 32'd0);
        check("rm_ent_data", ENT_WRITEDATA, 32'd0);
        check("rm_irq", {31'd0, IRQ}, 32'd0);
        chk_status("rm_status", 32'd0);
        check("rm_sb_drained", sb.size(), 0);
        sb.delete();
        tick();
        RESET = 1'b0;
        tick();
        chk_status("rm_status_rel", 32'd0);
        rd_csr(2'd0, rd);
        check("rm_stage_addr", rd, 32'd0);
        base = ent_cnt;
        tick();
        tick();
        tick();
        check("rm_no_resume", ent_cnt - base, 0);
        VBLANK = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
